// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: playfield geometry,
// coordinate type and the collision detector state encoding.
package snake_pkg;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int COORD_W = 4;
  localparam int MAX_LEN = 50;
  localparam int LEN_W   = 6;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } cd_state_t;

endpackage

// File: rtl/collision_detector.sv
// Per-step collision check of the new snake head against walls, body and apple;
// body segments are streamed from a synchronous-read memory, one per cycle.
module collision_detector
  import snake_pkg::*;
#(
  parameter int GRID_W  = snake_pkg::GRID_W,
  parameter int GRID_H  = snake_pkg::GRID_H,
  parameter int COORD_W = snake_pkg::COORD_W,
  parameter int MAX_LEN = snake_pkg::MAX_LEN,
  parameter int LEN_W   = snake_pkg::LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [COORD_W-1:0] headX,
  input  logic [COORD_W-1:0] headY,
  input  logic [COORD_W-1:0] appleX,
  input  logic [COORD_W-1:0] appleY,
  input  logic [LEN_W-1:0]   snakeLen,
  output logic [LEN_W-1:0]   bodyAddr,
  input  logic [COORD_W-1:0] bodyX,
  input  logic [COORD_W-1:0] bodyY,
  output logic               busy,
  output logic               goodColl,
  output logic               badColl,
  output logic               done
);

  // Compare one bit wider so an out-of-range limit never folds to a constant.
  function automatic logic wall_hit(input logic [COORD_W-1:0] x,
                                    input logic [COORD_W-1:0] y);
    return ({1'b0, x} >= (COORD_W+1)'(GRID_W)) ||
           ({1'b0, y} >= (COORD_W+1)'(GRID_H));
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
  endfunction

  cd_state_t          state_q, state_d;
  logic [LEN_W-1:0]   addr_q, addr_d;
  logic               bad_q, bad_d;
  logic               vld_p1_q, vld_p1_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               good_q, good_d;
  logic               badc_q, badc_d;

  logic [COORD_W-1:0] hx_q, hy_q, ax_q, ay_q;
  logic [COORD_W-1:0] hx_d, hy_d, ax_d, ay_d;
  logic [LEN_W-1:0]   len_q, len_d;

  logic               wall;
  logic               match;
  logic               bad_now;

  assign wall    = wall_hit(headX, headY);
  assign match   = vld_p1_q && (bodyX == hx_q) && (bodyY == hy_q);
  assign bad_now = bad_q | match;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    bad_d    = bad_q;
    vld_p1_d = (state_q == SCAN);
    busy_d   = 1'b0;
    done_d   = 1'b0;
    good_d   = 1'b0;
    badc_d   = 1'b0;
    hx_d     = hx_q;
    hy_d     = hy_q;
    ax_d     = ax_q;
    ay_d     = ay_q;
    len_d    = len_q;
    case (state_q)
      IDLE: begin
        if (step) begin
          hx_d   = headX;
          hy_d   = headY;
          ax_d   = appleX;
          ay_d   = appleY;
          len_d  = clamp_len(snakeLen);
          addr_d = '0;
          bad_d  = wall;
          busy_d = 1'b1;
          if (wall || (clamp_len(snakeLen) == '0)) begin
            state_d = REPORT;
            done_d  = 1'b1;
            badc_d  = wall;
            good_d  = !wall && (headX == appleX) && (headY == appleY);
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        busy_d = 1'b1;
        bad_d  = bad_now;
        if (addr_q == len_q - LEN_W'(1)) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + LEN_W'(1);
        end
      end
      DRAIN: begin
        // Last segment's data arrives here; the result registers load on this edge.
        busy_d  = 1'b1;
        bad_d   = bad_now;
        state_d = REPORT;
        done_d  = 1'b1;
        badc_d  = bad_now;
        good_d  = !bad_now && (hx_q == ax_q) && (hy_q == ay_q);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      bad_q    <= 1'b0;
      vld_p1_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      good_q   <= 1'b0;
      badc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bad_q    <= bad_d;
      vld_p1_q <= vld_p1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      good_q   <= good_d;
      badc_q   <= badc_d;
    end
  end

  always_ff @(posedge clk) begin
    hx_q  <= hx_d;
    hy_q  <= hy_d;
    ax_q  <= ax_d;
    ay_q  <= ay_d;
    len_q <= len_d;
  end

  assign bodyAddr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign goodColl = good_q;
  assign badColl  = badc_q;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: directed scenarios plus randomized checks
// against a behavioural model, with a synchronous-read body memory.
module tb_collision_detector;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 12;
  localparam int COORD_W = 5;
  localparam int MAX_LEN = 50;
  localparam int LEN_W   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               step;
  logic [COORD_W-1:0] headX, headY, appleX, appleY;
  logic [LEN_W-1:0]   snakeLen;
  logic [LEN_W-1:0]   bodyAddr;
  logic [COORD_W-1:0] bodyX, bodyY;
  logic               busy, goodColl, badColl, done;

  logic [COORD_W-1:0] mem_x [64];
  logic [COORD_W-1:0] mem_y [64];

  int checks = 0;
  int errors = 0;

  collision_detector #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .COORD_W(COORD_W),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .headX   (headX),
    .headY   (headY),
    .appleX  (appleX),
    .appleY  (appleY),
    .snakeLen(snakeLen),
    .bodyAddr(bodyAddr),
    .bodyX   (bodyX),
    .bodyY   (bodyY),
    .busy    (busy),
    .goodColl(goodColl),
    .badColl (badColl),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read body memory: data for an address appears one cycle later.
  always @(posedge clk) begin
    bodyX <= mem_x[bodyAddr];
    bodyY <= mem_y[bodyAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " bodyAddr"}, 32'(bodyAddr), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " goodColl"}, 32'(goodColl), 0);
    chk({tag, " badColl"}, 32'(badColl), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_body(input int n, input int hx, input int hy);
    for (int i = 0; i < 64; i++) begin
      do begin
        mem_x[i] = COORD_W'($urandom_range(0, GRID_W - 1));
        mem_y[i] = COORD_W'($urandom_range(0, GRID_H - 1));
      end while (int'(mem_x[i]) == hx && int'(mem_y[i]) == hy && i < n);
    end
  endtask

  // Caller is in cycle 0; returns in the cycle after the result cycle.
  task automatic run_check(input string name, input int hx, input int hy,
                           input int ax, input int ay, input int len, input bit noise);
    int  eff, rc;
    bit  wall, bad, good;
    eff  = (len > MAX_LEN) ? MAX_LEN : len;
    wall = (hx >= GRID_W) || (hy >= GRID_H);
    bad  = wall;
    if (!wall)
      for (int i = 0; i < eff; i++)
        if (int'(mem_x[i]) == hx && int'(mem_y[i]) == hy) bad = 1'b1;
    good = !bad && (hx == ax) && (hy == ay);
    rc   = (wall || eff == 0) ? 1 : eff + 2;

    headX    = COORD_W'(hx);
    headY    = COORD_W'(hy);
    appleX   = COORD_W'(ax);
    appleY   = COORD_W'(ay);
    snakeLen = LEN_W'(len);
    step     = 1'b1;
    for (int c = 1; c <= rc + 1; c++) begin
      tick();
      step = 1'b0;
      if (noise && c <= rc && (c == 2 || c == 4 || c == rc)) begin
        step     = 1'b1;
        headX    = COORD_W'($urandom);
        headY    = COORD_W'($urandom);
        appleX   = COORD_W'($urandom);
        appleY   = COORD_W'($urandom);
        snakeLen = LEN_W'($urandom);
      end
      chk($sformatf("%s busy c%0d", name, c), 32'(busy), 32'(c <= rc));
      chk($sformatf("%s done c%0d", name, c), 32'(done), 32'(c == rc));
      chk($sformatf("%s goodColl c%0d", name, c), 32'(goodColl), 32'(c == rc && good));
      chk($sformatf("%s badColl c%0d", name, c), 32'(badColl), 32'(c == rc && bad));
      if (rc == 1)
        chk($sformatf("%s bodyAddr c%0d", name, c), 32'(bodyAddr), 0);
      else if (c <= eff)
        chk($sformatf("%s bodyAddr c%0d", name, c), 32'(bodyAddr), 32'(c - 1));
    end
    step = 1'b0;
  endtask

  initial begin
    int hx, hy, ax, ay, len, pos;
    rst = 1'b1;
    step = 1'b0;
    headX = '0; headY = '0; appleX = '0; appleY = '0; snakeLen = '0;
    for (int i = 0; i < 64; i++) begin
      mem_x[i] = '0;
      mem_y[i] = '0;
    end
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    run_check("len0_apple", 3, 3, 3, 3, 0, 1'b0);
    run_check("wall_x", 16, 2, 16, 2, 0, 1'b0);
    run_check("wall_y", 4, 12, 9, 9, 5, 1'b0);

    mem_x[0] = 5; mem_y[0] = 6;
    mem_x[1] = 5; mem_y[1] = 7;
    mem_x[2] = 5; mem_y[2] = 5;
    run_check("self_hit", 5, 5, 9, 9, 3, 1'b0);

    mem_x[0] = 4; mem_y[0] = 5;
    mem_x[1] = 4; mem_y[1] = 6;
    run_check("apple_scan", 4, 4, 4, 4, 2, 1'b0);

    mem_x[0] = 5; mem_y[0] = 6;
    mem_x[1] = 5; mem_y[1] = 7;
    mem_x[2] = 5; mem_y[2] = 5;
    run_check("ignored_steps", 5, 5, 9, 9, 3, 1'b1);

    fill_body(63, 7, 7);
    run_check("clamp_len", 7, 7, 7, 7, 63, 1'b0);
    mem_x[49] = 7; mem_y[49] = 7;
    run_check("hit_last", 7, 7, 7, 7, 50, 1'b0);

    // Reset in cycle 2 of a len=10 scan aborts without any result pulse.
    fill_body(10, 2, 2);
    headX = 2; headY = 2; appleX = 2; appleY = 2; snakeLen = 10;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("rst_scan busy c2", 32'(busy), 1);
    chk("rst_scan bodyAddr c2", 32'(bodyAddr), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_scan c3");
    tick();
    chk_idle("rst_scan c4");
    run_check("after_rst", 2, 2, 2, 2, 10, 1'b0);

    for (int n = 0; n < 40; n++) begin
      hx  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, GRID_W - 1);
      hy  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(0, GRID_H - 1);
      ax  = $urandom_range(0, 1) ? hx : $urandom_range(0, GRID_W - 1);
      ay  = $urandom_range(0, 1) ? hy : $urandom_range(0, GRID_H - 1);
      len = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 55);
      fill_body(64, hx, hy);
      if ($urandom_range(0, 2) == 0) begin
        pos = $urandom_range(0, 63);
        mem_x[pos] = COORD_W'(hx);
        mem_y[pos] = COORD_W'(hy);
      end
      run_check($sformatf("rand%0d", n), hx, hy, ax, ay, len, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Event source for the scoring path: on each snake move step, checks the new head position against the walls, the snake body and the apple, then emits one-cycle `goodColl`/`badColl` pulses in exactly the form the score tracker consumes. It sits between the snake movement/body-storage logic and the score display. Body segments are read serially from a synchronous-read body memory, one per cycle.

## Interface
Parameters:
- `GRID_W`, default 16: playfield width in cells; legal X is 0..GRID_W-1.
- `GRID_H`, default 12: playfield height in cells; legal Y is 0..GRID_H-1.
- `COORD_W`, default 4: coordinate width.
- `MAX_LEN`, default 50: maximum body segments, head excluded.
- `LEN_W`, default 6: width of the length and address fields.

Ports:
- `clk`, in, 1: system clock. The block uses this one clock only.
- `rst`, in, 1: reset. It is synchronous and active-high.
- `step`, in, 1: one-cycle pulse that starts a check.
- `headX`, `headY`, in, COORD_W each: new head position, sampled with `step`.
- `appleX`, `appleY`, in, COORD_W each: apple position, sampled with `step`.
- `snakeLen`, in, LEN_W: body segment count, 0..MAX_LEN, sampled with `step`.
- `bodyAddr`, out, LEN_W: body memory read address, registered.
- `bodyX`, `bodyY`, in, COORD_W each: body memory read data, valid one cycle after `bodyAddr`.
- `busy`, out, 1: high from the cycle after an accepted `step` through the result cycle.
- `goodColl`, out, 1: one-cycle pulse, apple eaten, no fatal hit.
- `badColl`, out, 1: one-cycle pulse, wall or self collision.
- `done`, out, 1: one-cycle pulse in the result cycle, every check.

## Operation
States:
- IDLE: accepts `step`.
  - Latches head, apple and `snakeLen`; `snakeLen` values above MAX_LEN are clamped to MAX_LEN.
  - Wall hit (headX ≥ GRID_W or headY ≥ GRID_H): set the bad flag and go to REPORT.
  - Else if the latched length is 0: go to REPORT.
  - Else go to SCAN with `bodyAddr` = 0.
- SCAN: advances `bodyAddr` by 1 per cycle up to len-1. Each returned `bodyX`/`bodyY` is compared to the latched head; any match sets the sticky bad flag. There is no early exit, so latency is deterministic. After the last address is issued, go to DRAIN.
- DRAIN: compares the final returned segment, then goes to REPORT.
- REPORT: drives `done`. Drives `badColl` if the bad flag is set. Otherwise drives `goodColl` if head equals apple. Returns to IDLE.

Rules:
- `badColl` has priority over `goodColl`; the two are never high together.
- `step` is ignored whenever `busy` is high. A `step` arriving in the REPORT cycle is also ignored.
- Flags clear on every accepted `step`.
- Reset values: `bodyAddr`=0, `busy`=0, `goodColl`=0, `badColl`=0, `done`=0, state IDLE, flags clear.
- `rst` asserted mid-scan aborts the check with no result pulse. All outputs read their reset values in the cycle after the `rst` edge.
- All comparisons are unsigned at COORD_W bits. An apple lying on a body cell is not checked here.

## Timing
- Cycle 0 is the cycle in which `step` is sampled high.
- Scan path: `bodyAddr`=k during cycle k+1, for k = 0..len-1. The data for address k is sampled at the end of cycle k+2. Result pulses occur in cycle len+2.
- Fast path (wall hit or len=0): result pulses occur in cycle 1.
- The earliest accepted next `step` is the cycle after REPORT.
- `busy` is high in cycles 1..result cycle inclusive.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `snake_pkg` holds:
  - constants GRID_W, GRID_H, COORD_W, MAX_LEN, LEN_W;
  - `typedef struct packed` `coord_t` {x, y};
  - `typedef enum` `cd_state_t` {IDLE, SCAN, DRAIN, REPORT}.
- No sub-module; the wall and equality checks are inline. The bench supplies a synchronous-read body memory model.

## Test plan
- Head (3,3), apple (3,3), len 0 → `goodColl` and `done` pulse in cycle 1; `badColl` stays 0.
- Head (16,2), apple (16,2) → `badColl` pulse in cycle 1; `goodColl` stays 0 (wall hit has priority); `bodyAddr` never leaves 0.
- Head (5,5), apple (9,9), body {(5,6),(5,7),(5,5)}, len 3 → `bodyAddr` reads 0,1,2 in cycles 1–3; `badColl` in cycle 5.
- Head (4,4), apple (4,4), body {(4,5),(4,6)}, len 2 → `goodColl` in cycle 4; `busy` high in cycles 1–4.
- Second `step` pulses in cycles 2 and 4 while len=3 → both ignored; exactly one result pulse, in cycle 5.
- `rst` asserted in cycle 2 of a len=10 scan → no result pulse; all outputs 0 from cycle 3; a fresh `step` in cycle 4 completes normally.
